// File: rtl/nios_fprint_event_timestamp_log_pkg.sv
// Shared definitions for the event timestamp log: the slave register map,
// STATUS/CONTROL bit positions, the timestamp width and the FIFO entry layout.
package nios_fprint_event_timestamp_log_pkg;

  localparam int TS_WIDTH   = 64;
  // Entries always reserve room for the largest supported event count so the
  // layout does not depend on the top-level parameter.
  localparam int MAX_EVENTS = 8;

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_CONTROL  = 4'd1;
  localparam logic [3:0] ADDR_HEAD_EVT = 4'd2;
  localparam logic [3:0] ADDR_HEAD_TS0 = 4'd3;
  localparam logic [3:0] ADDR_HEAD_TS1 = 4'd4;
  localparam logic [3:0] ADDR_HEAD_TS2 = 4'd5;
  localparam logic [3:0] ADDR_HEAD_TS3 = 4'd6;
  localparam logic [3:0] ADDR_POP      = 4'd7;
  localparam logic [3:0] ADDR_FLUSH    = 4'd8;
  localparam logic [3:0] ADDR_NOW_TS0  = 4'd9;
  localparam logic [3:0] ADDR_NOW_TS1  = 4'd10;
  localparam logic [3:0] ADDR_NOW_TS2  = 4'd11;
  localparam logic [3:0] ADDR_NOW_TS3  = 4'd12;

  localparam int ST_NONEMPTY     = 0;
  localparam int ST_FULL         = 1;
  localparam int ST_OVERFLOW     = 2;
  localparam int ST_COUNT_LSB    = 8;
  localparam int CTRL_IRQ_EN     = 0;
  localparam int CTRL_CAPTURE_EN = 1;
  localparam int CTRL_MASK_LSB   = 8;

  typedef struct packed {
    logic [MAX_EVENTS-1:0] evt;
    logic [TS_WIDTH-1:0]   ts;
  } entry_t;

  // Select one 16-bit halfword of a timestamp, 0 = least significant.
  function automatic logic [15:0] ts_half(input logic [TS_WIDTH-1:0] ts,
                                          input logic [1:0] sel);
    return ts[16*sel +: 16];
  endfunction

endpackage

// File: rtl/nios_fprint_event_timestamp_log_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports: clk, reset_n (sync, active-low); push/push_data write the tail;
// pop drops the head; flush empties the queue and discards a same-cycle push;
// head_data is the current head (combinational); count/full/empty status.
// A push while full succeeds when a pop happens in the same cycle.
module nios_fprint_sync_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             push_eff, pop_eff;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_eff  = pop & ~empty & ~flush;
  // Full is only a blocker when nothing leaves the queue in the same cycle.
  assign push_eff = push & ~flush & (~full | pop_eff);

  always_comb begin
    count_next = count_reg;
    case ({push_eff, pop_eff})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/nios_fprint_event_timestamp_log.sv
// Event timestamp log: records rising edges on event_in against a free-running
// 64-bit counter into a FIFO drained through a 16-bit register slave.
// Ports: clk, reset_n (sync, active-low); address/chipselect/write_n/writedata
// slave write side; readdata registered read data (1-cycle latency);
// event_in event levels; irq = irq_en & FIFO nonempty.
module nios_fprint_event_timestamp_log
  import nios_fprint_event_timestamp_log_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [15:0]           writedata,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic [15:0]           readdata,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TS_WIDTH-1:0]   ts_counter_reg;
  logic [TS_WIDTH-1:0]   now_snap_reg;
  logic [NUM_EVENTS-1:0] prev_reg;
  logic [NUM_EVENTS-1:0] mask_reg;
  logic                  irq_en_reg, capture_en_reg, overflow_reg;
  logic [15:0]           readdata_reg;
  logic [15:0]           rd_mux;

  logic [NUM_EVENTS-1:0] rise;
  logic                  wr_en, pop_req, flush_req, push_req, drop;
  entry_t                push_entry, head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_rise
      assign rise[gi] = event_in[gi] & ~prev_reg[gi] & mask_reg[gi];
    end
  endgenerate

  assign wr_en     = chipselect & ~write_n;
  assign pop_req   = wr_en & (address == ADDR_POP);
  assign flush_req = wr_en & (address == ADDR_FLUSH);
  assign push_req  = capture_en_reg & (|rise);
  // A flush discards the push outright, so that case is not an overflow.
  assign drop      = push_req & fifo_full & ~pop_req & ~flush_req;

  assign push_entry.evt = MAX_EVENTS'(rise);
  assign push_entry.ts  = ts_counter_reg;

  nios_fprint_sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_req),
    .push_data(push_entry),
    .pop      (pop_req),
    .flush    (flush_req),
    .head_data(head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_counter_reg <= '0;
      now_snap_reg   <= '0;
      prev_reg       <= '0;
      mask_reg       <= '0;
      irq_en_reg     <= 1'b0;
      capture_en_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      readdata_reg   <= '0;
    end else begin
      ts_counter_reg <= ts_counter_reg + TS_WIDTH'(1);
      prev_reg       <= event_in;
      // Drop wins over a same-cycle clear so no lost entry goes unreported.
      if (drop)
        overflow_reg <= 1'b1;
      else if (wr_en && address == ADDR_STATUS)
        overflow_reg <= 1'b0;
      if (wr_en && address == ADDR_CONTROL) begin
        irq_en_reg     <= writedata[CTRL_IRQ_EN];
        capture_en_reg <= writedata[CTRL_CAPTURE_EN];
        mask_reg       <= writedata[CTRL_MASK_LSB +: NUM_EVENTS];
      end
      if (wr_en && address == ADDR_NOW_TS0)
        now_snap_reg <= ts_counter_reg;
      readdata_reg <= chipselect ? rd_mux : 16'h0000;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS: begin
        rd_mux[ST_COUNT_LSB +: 8] = 8'(fifo_count);
        rd_mux[ST_OVERFLOW]       = overflow_reg;
        rd_mux[ST_FULL]           = fifo_full;
        rd_mux[ST_NONEMPTY]       = ~fifo_empty;
      end
      ADDR_CONTROL: begin
        rd_mux[CTRL_MASK_LSB +: 8]  = 8'(mask_reg);
        rd_mux[CTRL_CAPTURE_EN]     = capture_en_reg;
        rd_mux[CTRL_IRQ_EN]         = irq_en_reg;
      end
      ADDR_HEAD_EVT:
        if (!fifo_empty) rd_mux = 16'(head.evt[NUM_EVENTS-1:0]);
      ADDR_HEAD_TS0, ADDR_HEAD_TS1, ADDR_HEAD_TS2, ADDR_HEAD_TS3:
        if (!fifo_empty) rd_mux = ts_half(head.ts, 2'(address - ADDR_HEAD_TS0));
      ADDR_NOW_TS0, ADDR_NOW_TS1, ADDR_NOW_TS2, ADDR_NOW_TS3:
        rd_mux = ts_half(now_snap_reg, 2'(address - ADDR_NOW_TS0));
      default: rd_mux = '0;
    endcase
  end

  assign readdata    = readdata_reg;
  assign irq         = irq_en_reg & ~fifo_empty;
  assign unused_bits = ^{writedata, head.evt};

endmodule

// File: tb/tb_nios_fprint_event_timestamp_log.sv
module tb_nios_fprint_event_timestamp_log;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [3:0]  event_in = '0;
  logic [15:0] readdata;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic [63:0] tb_ts;
  logic [63:0] exp_ts [16];
  logic [63:0] t_new;
  logic [15:0] rd;

  always #5 clk = ~clk;

  // Reference counter: 0 while reset is held, +1 on every other clock.
  always @(posedge clk) begin
    if (!reset_n) tb_ts <= '0;
    else tb_ts <= tb_ts + 64'd1;
  end

  nios_fprint_event_timestamp_log #(.NUM_EVENTS(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .event_in(event_in),
    .readdata(readdata), .irq(irq)
  );

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  task automatic pulse_events(input logic [3:0] bits);
    event_in = bits;
    @(negedge clk);
    event_in = '0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    total++; if (readdata !== 16'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0000", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    repeat (10) @(negedge clk);
    bus_write(4'd9, 16'h0);
    bus_read(4'd9, rd);
    total++; if (rd !== 16'd10) begin bad++; $display("FAIL now_ts0 got=%h want=000a", rd); end
    bus_read(4'd10, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL now_ts1 got=%h want=0000", rd); end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_status got=%h want=0000", rd); end
    bus_read(4'd3, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_head_ts0 got=%h want=0000", rd); end
  endtask

  task automatic test_single_event;
    bus_write(4'd1, 16'hFF03);
    bus_read(4'd1, rd);
    total++; if (rd !== 16'h0F03) begin bad++; $display("FAIL control_rb got=%h want=0f03", rd); end
    for (int n = 0; n < 20000 && tb_ts != 64'h1234; n++) @(negedge clk);
    total++; if (tb_ts !== 64'h1234) begin bad++; $display("FAIL wait_1234 got=%h want=1234", tb_ts); end
    pulse_events(4'b0100);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%b want=1", irq); end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0101) begin bad++; $display("FAIL single_status got=%h want=0101", rd); end
    bus_read(4'd2, rd);
    total++; if (rd !== 16'h0004) begin bad++; $display("FAIL single_evt got=%h want=0004", rd); end
    bus_read(4'd3, rd);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL single_ts0 got=%h want=1234", rd); end
    for (int i = 4; i <= 6; i++) begin
      bus_read(4'(i), rd);
      total++; if (rd !== 16'h0) begin bad++; $display("FAIL single_ts_hi%0d got=%h want=0000", i, rd); end
    end
    bus_write(4'd7, 16'h0);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL pop_status got=%h want=0000", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pop_irq got=%b want=0", irq); end
  endtask

  task automatic test_simultaneous;
    pulse_events(4'b1001);
    bus_read(4'd2, rd);
    total++; if (rd !== 16'h0009) begin bad++; $display("FAIL simul_evt got=%h want=0009", rd); end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0101) begin bad++; $display("FAIL simul_status got=%h want=0101", rd); end
    bus_write(4'd7, 16'h0);
  endtask

  task automatic test_overflow;
    bus_write(4'd1, 16'h0F02);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_ts[i] = tb_ts;
      pulse_events(4'b0010);
    end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h1007) begin bad++; $display("FAIL ovf_status got=%h want=1007", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq got=%b want=0", irq); end
    bus_write(4'd0, 16'h0);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h1003) begin bad++; $display("FAIL ovf_clear got=%h want=1003", rd); end
    for (int i = 0; i < 16; i++) begin
      bus_read(4'd3, rd);
      total++; if (rd !== exp_ts[i][15:0]) begin bad++; $display("FAIL drain_ts0[%0d] got=%h want=%h", i, rd, exp_ts[i][15:0]); end
      bus_read(4'd4, rd);
      total++; if (rd !== exp_ts[i][31:16]) begin bad++; $display("FAIL drain_ts1[%0d] got=%h want=%h", i, rd, exp_ts[i][31:16]); end
      bus_write(4'd7, 16'h0);
    end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL drained_status got=%h want=0000", rd); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) pulse_events(4'b0010);
    // Pop and a new edge land on the same clock edge.
    address = 4'd7; chipselect = 1'b1; write_n = 1'b0; event_in = 4'b0010;
    t_new = tb_ts;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; event_in = '0;
    @(negedge clk);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h1003) begin bad++; $display("FAIL fullpp_status got=%h want=1003", rd); end
    for (int i = 0; i < 15; i++) bus_write(4'd7, 16'h0);
    bus_read(4'd3, rd);
    total++; if (rd !== t_new[15:0]) begin bad++; $display("FAIL tail_ts0 got=%h want=%h", rd, t_new[15:0]); end
    bus_read(4'd4, rd);
    total++; if (rd !== t_new[31:16]) begin bad++; $display("FAIL tail_ts1 got=%h want=%h", rd, t_new[31:16]); end
    bus_write(4'd7, 16'h0);
    bus_write(4'd1, 16'h0D02);
    pulse_events(4'b0010);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL masked_status got=%h want=0000", rd); end
    pulse_events(4'b0001);
    bus_read(4'd2, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL unmasked_evt got=%h want=0001", rd); end
    bus_write(4'd8, 16'h0);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL flush_status got=%h want=0000", rd); end
    bus_write(4'd7, 16'h0);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL empty_pop got=%h want=0000", rd); end
    // Flush and a new edge together: the edge is discarded.
    address = 4'd8; chipselect = 1'b1; write_n = 1'b0; event_in = 4'b0001;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; event_in = '0;
    @(negedge clk);
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL flush_push got=%h want=0000", rd); end
  endtask

  task automatic test_wrap_and_reset;
    bus_write(4'd1, 16'h0F03);
    force dut.ts_counter_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    event_in = 4'b0001;
    @(negedge clk);
    force dut.ts_counter_reg = 64'h0;
    event_in = 4'b0010;
    @(negedge clk);
    release dut.ts_counter_reg;
    event_in = '0;
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq got=%b want=1", irq); end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0201) begin bad++; $display("FAIL wrap_status got=%h want=0201", rd); end
    bus_read(4'd2, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL wrap_evt0 got=%h want=0001", rd); end
    for (int i = 3; i <= 6; i++) begin
      bus_read(4'(i), rd);
      total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL wrap_max_ts%0d got=%h want=ffff", i - 3, rd); end
    end
    bus_write(4'd7, 16'h0);
    bus_read(4'd2, rd);
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL wrap_evt1 got=%h want=0002", rd); end
    for (int i = 3; i <= 6; i++) begin
      bus_read(4'(i), rd);
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL wrap_zero_ts%0d got=%h want=0000", i - 3, rd); end
    end
    // Reset with one entry still queued.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b want=0", irq); end
    bus_write(4'd9, 16'h0);
    bus_read(4'd9, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midreset_now got=%h want=0000", rd); end
    bus_read(4'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midreset_status got=%h want=0000", rd); end
    bus_read(4'd1, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL midreset_control got=%h want=0000", rd); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single_event;
    test_simultaneous;
    test_overflow;
    test_full_push_pop;
    test_wrap_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
